mcu_link_rx: RTL and testbench
==============================

# mcu_link_rx

MCU-side receiver for one rocstar uplink: deserializes the 8-bit `to_mcu` byte stream produced by a board's `rocstar_mcu_link` (e.g. `A1in`/`B1in` of `mcu_logic`) into framed messages. It delivers single-photon words through a small first-word-fall-through FIFO to the coincidence logic, and delivers saved-clock reports as one-cycle pulses. It also keeps saturating error and overflow counters for bus readout. One instance is used per rocstar port.

## Interface
- `FIFO_AW`, default 2: log2 of the single-word FIFO depth (default depth 4).

- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset; asynchronous, active-high.
- `rx`  in  8  byte from the rocstar, sampled on every posedge `clk`.
- `clr_cnt`  in  1  synchronous clear of all three counters.
- `sp_ready`  in  1  consumer accepts `sp_word` when `sp_valid && sp_ready`.
- `sp_valid`  out  1  FIFO non-empty.
- `sp_word`  out  16  FIFO head (single-photon word).
- `clk_valid`  out  1  one-cycle pulse; no backpressure.
- `clk_word`  out  48  last received clock report; held until the next report.
- `frame_err_cnt`  out  16  saturating count of framing errors.
- `csum_err_cnt`  out  16  saturating count of checksum failures.
- `ovf_cnt`  out  16  saturating count of singles dropped because the FIFO was full.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- Byte classes:
  - `rx[7]=1` is a header; `rx[6:5]` gives the type.
  - `rx[7]=0` is payload inside a frame, or idle outside a frame. Idle bytes are ignored whatever their value.
- Header types:
  - 00: single frame, 3 payload bytes.
  - 01: clock-report frame, 7 payload bytes.
  - 1x: reserved. Counts as a frame error (`frame_err_cnt`+1); FSM stays in or returns to IDLE.
- Single payload layout:
  - P0[6:0] = sp[15:9].
  - P1[6:0] = sp[8:2].
  - P2[6:5] = sp[1:0].
  - P2[4] is ignored.
  - P2[3:0] = checksum = sp[15:12]^sp[11:8]^sp[7:4]^sp[3:0].
- Single frame handling: on a checksum match the word is pushed to the FIFO. On a mismatch the word is dropped and `csum_err_cnt`+1.
- Clock payload: P0..P6, 7 bits each, MSB first, 49 bits total. Bit 48 is discarded and bits 47:0 go to `clk_word`. No checksum.
- FSM states:
  - IDLE: a header of type 00 goes to SP; type 01 goes to CK.
  - SP, with byte index 0..2: returns to IDLE after the byte with index 2.
  - CK, with byte index 0..6: returns to IDLE after the byte with index 6.
- Header received while in SP or CK:
  - The current frame is aborted and `frame_err_cnt`+1.
  - The same byte is decoded as a new header in that same cycle, so a valid header enters SP or CK directly.
- FIFO push when full:
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the new word is dropped and `ovf_cnt`+1.
  - FIFO order is strictly preserved.
- Counters:
  - All three saturate at 16'hFFFF.
  - `clr_cnt` wins over a coincident increment; the result is 0.

## Timing
- Reset state:
  - FSM in IDLE, byte index 0, FIFO empty.
  - All outputs 0: `sp_valid`, `sp_word`, `clk_valid`, `clk_word`, all counters, `busy`.
  - Reset asserted mid-frame discards the partial frame. Payload bytes that follow after release are idle bytes, and no error is counted.
- Single latency: last payload byte sampled at edge N. If the FIFO was empty, `sp_valid`=1 and `sp_word` are valid after edge N. A word can be popped at edge N+1.
- Pop: occurs at an edge where `sp_valid && sp_ready`. The next entry, or `sp_valid`=0, appears after that edge.
- Clock latency: last payload byte at edge N. `clk_word` updates and `clk_valid`=1 after edge N, for exactly one cycle.
- Throughput: back-to-back frames with no idle bytes in between are supported, at one byte per cycle.
- `busy` reflects the state after each edge.

## Test plan
- Single frame: rx = 80,5F,3B,64, then 00 → after edge 4, `sp_valid`=1 and `sp_word`=BEEF. Pop with `sp_ready`=1 → `sp_valid`=0 one cycle later. All counters remain 0.
- Clock report: rx = A0,00,00,00,00,00,24,34 → one-cycle `clk_valid` with `clk_word`=48'h1234. `sp_valid` stays 0.
- Checksum error: rx = 80,5F,3B,65 → no `sp_valid`; `csum_err_cnt`=1.
- Abort and reserved header: rx = 80,5F,80,5F,3B,64,C0 → `frame_err_cnt`=2 and exactly one BEEF is delivered.
- Overflow: `sp_ready`=0, then five BEEF frames → `ovf_cnt`=1. Raising `sp_ready` pops 4 words, then `sp_valid`=0. Then `clr_cnt` pulse → all counters 0.
- Reset mid-frame: rx = 80,5F, `rst` pulse, then 3B,64 → no output; all counters 0; `busy`=0.

Source files
------------

// File: rtl/mcu_link_rx.sv
// mcu_link_rx: deframes the rocstar to_mcu byte stream into single-photon words (FIFO)
// and clock reports (pulse), with saturating frame/checksum/overflow counters.
module mcu_link_rx #(
   parameter int FIFO_AW = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx,
   input  logic        clr_cnt,
   input  logic        sp_ready,
   output logic        sp_valid,
   output logic [15:0] sp_word,
   output logic        clk_valid,
   output logic [47:0] clk_word,
   output logic [15:0] frame_err_cnt,
   output logic [15:0] csum_err_cnt,
   output logic [15:0] ovf_cnt,
   output logic        busy
);
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {IDLE, SP, CK} state_t;

   state_t               state, state_n;
   logic [2:0]           idx, idx_n;
   logic [47:0]          sh;
   logic [1:0]           fe_inc;
   logic                 sp_done, ck_done, csum_ok;
   logic                 pop, push_req, push, full, ovf;
   logic [15:0]          sp_new;
   logic [15:0]          mem [DEPTH];
   logic [FIFO_AW-1:0]   wp, rp;
   logic [FIFO_AW:0]     cnt;

   function automatic logic [15:0] bump(input logic [15:0] c, input logic [1:0] inc, input logic clr);
      logic [16:0] s;
      s = {1'b0, c} + {15'b0, inc};
      return clr ? 16'h0 : (s[16] ? 16'hFFFF : s[15:0]);
   endfunction

   // A header always restarts framing; an abort and a reserved type on the same byte both count
   always_comb begin
      state_n = state;
      idx_n   = idx;
      fe_inc  = 2'd0;
      sp_done = 1'b0;
      ck_done = 1'b0;
      if (rx[7]) begin
         idx_n   = 3'd0;
         fe_inc  = {1'b0, state != IDLE} + {1'b0, rx[6]};
         state_n = rx[6] ? IDLE : (rx[5] ? CK : SP);
      end else if (state != IDLE) begin
         sp_done = (state == SP) && (idx == 3'd2);
         ck_done = (state == CK) && (idx == 3'd6);
         idx_n   = (sp_done || ck_done) ? 3'd0 : idx + 3'd1;
         state_n = (sp_done || ck_done) ? IDLE : state;
      end
   end

   assign sp_new   = {sh[13:0], rx[6:5]};
   assign csum_ok  = (sp_new[15:12] ^ sp_new[11:8] ^ sp_new[7:4] ^ sp_new[3:0]) == rx[3:0];
   assign sp_valid = cnt != '0;
   assign sp_word  = sp_valid ? mem[rp] : 16'h0;
   assign busy     = state != IDLE;
   assign pop      = sp_valid && sp_ready;
   assign full     = cnt == (FIFO_AW + 1)'(DEPTH);
   assign push_req = sp_done && csum_ok;
   assign push     = push_req && (!full || pop);
   assign ovf      = push_req && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= 3'd0;
         sh            <= 48'h0;
         clk_valid     <= 1'b0;
         clk_word      <= 48'h0;
         wp            <= '0;
         rp            <= '0;
         cnt           <= '0;
         frame_err_cnt <= 16'h0;
         csum_err_cnt  <= 16'h0;
         ovf_cnt       <= 16'h0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         clk_valid <= ck_done;
         if (!rx[7] && state != IDLE) sh <= {sh[40:0], rx[6:0]};
         if (ck_done) clk_word <= {sh[40:0], rx[6:0]};
         if (push) begin
            mem[wp] <= sp_new;
            wp      <= wp + FIFO_AW'(1);
         end
         if (pop) rp <= rp + FIFO_AW'(1);
         cnt           <= cnt + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
         frame_err_cnt <= bump(frame_err_cnt, fe_inc, clr_cnt);
         csum_err_cnt  <= bump(csum_err_cnt, {1'b0, sp_done && !csum_ok}, clr_cnt);
         ovf_cnt       <= bump(ovf_cnt, {1'b0, ovf}, clr_cnt);
      end
   end
endmodule

// File: tb/tb_mcu_link_rx.sv
// tb_mcu_link_rx: directed scenarios plus randomized frame traffic checked against a
// byte-level message model of the uplink receiver.
module tb_mcu_link_rx;
   logic        clk = 0, rst = 1, clr_cnt = 0, sp_ready = 0;
   logic [7:0]  rx = 0;
   logic        sp_valid, clk_valid, busy;
   logic [15:0] sp_word, frame_err_cnt, csum_err_cnt, ovf_cnt;
   logic [47:0] clk_word;
   int          checks = 0, passed = 0;

   int          q[$];
   int          pay[$];
   bit          in_frame;
   int          ftype;
   bit          e_cv;
   logic [47:0] e_cw;
   int          e_fe, e_ce, e_oc;

   mcu_link_rx dut (
      .clk(clk), .rst(rst), .rx(rx), .clr_cnt(clr_cnt), .sp_ready(sp_ready),
      .sp_valid(sp_valid), .sp_word(sp_word), .clk_valid(clk_valid), .clk_word(clk_word),
      .frame_err_cnt(frame_err_cnt), .csum_err_cnt(csum_err_cnt), .ovf_cnt(ovf_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      q.delete(); pay.delete();
      in_frame = 0; ftype = 0; e_cv = 0; e_cw = 0;
      e_fe = 0; e_ce = 0; e_oc = 0;
   endtask

   // Message-level view: collect a frame's payload bytes, then interpret the whole frame
   task automatic model_edge(input logic [7:0] b, input logic r, input logic c);
      int fi, ci, oi, w, cs;
      bit popped, full;
      longint v;
      fi = 0; ci = 0; oi = 0;
      full = q.size() == 4;
      popped = q.size() > 0 && r;
      if (popped) void'(q.pop_front());
      e_cv = 0;
      if (b[7]) begin
         if (in_frame) fi++;
         in_frame = 0;
         pay.delete();
         if (b[6]) fi++;
         else begin in_frame = 1; ftype = int'(b[5]); end
      end else if (in_frame) begin
         pay.push_back(int'(b) % 128);
         if (pay.size() == (ftype ? 7 : 3)) begin
            if (ftype == 0) begin
               w  = pay[0] * 512 + pay[1] * 4 + pay[2] / 32;
               cs = (w / 4096) ^ ((w / 256) % 16) ^ ((w / 16) % 16) ^ (w % 16);
               if (cs != pay[2] % 16) ci++;
               else if (!full || popped) q.push_back(w);
               else oi++;
            end else begin
               v = 0;
               foreach (pay[i]) v = v * 128 + pay[i];
               e_cw = v[47:0];
               e_cv = 1;
            end
            in_frame = 0;
            pay.delete();
         end
      end
      e_fe = c ? 0 : (e_fe + fi > 65535 ? 65535 : e_fe + fi);
      e_ce = c ? 0 : (e_ce + ci > 65535 ? 65535 : e_ce + ci);
      e_oc = c ? 0 : (e_oc + oi > 65535 ? 65535 : e_oc + oi);
   endtask

   task automatic step(input logic [7:0] b, input logic r, input logic c);
      rx = b; sp_ready = r; clr_cnt = c;
      @(posedge clk);
      model_edge(b, r, c);
      #1;
   endtask

   task automatic do_reset();
      rx = 0; sp_ready = 0; clr_cnt = 0; rst = 1;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({sp_valid, sp_word, clk_valid, clk_word, frame_err_cnt, csum_err_cnt, ovf_cnt, busy} !== '0)
         $display("FAIL reset_outputs: got v=%b w=%h cv=%b cw=%h fe=%0d ce=%0d oc=%0d busy=%b, want all 0",
                  sp_valid, sp_word, clk_valid, clk_word, frame_err_cnt, csum_err_cnt, ovf_cnt, busy);
      else passed++;
   endtask

   task automatic test_single();
      do_reset();
      step(8'h80, 0, 0); step(8'h5F, 0, 0); step(8'h3B, 0, 0); step(8'h64, 0, 0);
      checks++;
      if (sp_valid !== 1'b1 || sp_word !== 16'hBEEF)
         $display("FAIL single_word: got v=%b w=%h, want v=1 w=beef", sp_valid, sp_word);
      else passed++;
      step(8'h00, 1, 0);
      checks++;
      if (sp_valid !== 1'b0) $display("FAIL single_pop: got v=%b, want 0", sp_valid);
      else passed++;
      checks++;
      if ({frame_err_cnt, csum_err_cnt, ovf_cnt, busy} !== '0)
         $display("FAIL single_counters: got fe=%0d ce=%0d oc=%0d busy=%b, want 0",
                  frame_err_cnt, csum_err_cnt, ovf_cnt, busy);
      else passed++;
   endtask

   task automatic test_clock();
      logic [7:0] b [8] = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h24, 8'h34};
      do_reset();
      foreach (b[i]) step(b[i], 0, 0);
      checks++;
      if (clk_valid !== 1'b1 || clk_word !== 48'h1234 || sp_valid !== 1'b0)
         $display("FAIL clock_report: got cv=%b cw=%h sv=%b, want cv=1 cw=1234 sv=0", clk_valid, clk_word, sp_valid);
      else passed++;
      step(8'h00, 0, 0);
      checks++;
      if (clk_valid !== 1'b0 || clk_word !== 48'h1234)
         $display("FAIL clock_pulse_hold: got cv=%b cw=%h, want cv=0 cw=1234", clk_valid, clk_word);
      else passed++;
   endtask

   task automatic test_csum();
      do_reset();
      step(8'h80, 0, 0); step(8'h5F, 0, 0); step(8'h3B, 0, 0); step(8'h65, 0, 0); step(8'h00, 0, 0);
      checks++;
      if (sp_valid !== 1'b0 || csum_err_cnt !== 16'd1 || frame_err_cnt !== 16'd0)
         $display("FAIL csum_error: got sv=%b ce=%0d fe=%0d, want sv=0 ce=1 fe=0", sp_valid, csum_err_cnt, frame_err_cnt);
      else passed++;
   endtask

   task automatic test_abort();
      logic [7:0] b [9] = '{8'h80, 8'h5F, 8'h80, 8'h5F, 8'h3B, 8'h64, 8'hC0, 8'h00, 8'h00};
      int n = 0;
      do_reset();
      foreach (b[i]) begin
         step(b[i], 1, 0);
         if (sp_valid && sp_word == 16'hBEEF) n++;
      end
      checks++;
      if (frame_err_cnt !== 16'd2 || n != 1 || busy !== 1'b0)
         $display("FAIL abort_reserved: got fe=%0d words=%0d busy=%b, want fe=2 words=1 busy=0", frame_err_cnt, n, busy);
      else passed++;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int f = 0; f < 5; f++) begin
         step(8'h80, 0, 0); step(8'h5F, 0, 0); step(8'h3B, 0, 0); step(8'h64, 0, 0);
      end
      checks++;
      if (ovf_cnt !== 16'd1 || sp_valid !== 1'b1)
         $display("FAIL overflow_count: got oc=%0d sv=%b, want oc=1 sv=1", ovf_cnt, sp_valid);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (sp_valid !== 1'b1 || sp_word !== 16'hBEEF)
            $display("FAIL overflow_drain%0d: got sv=%b w=%h, want sv=1 w=beef", i, sp_valid, sp_word);
         else passed++;
         step(8'h00, 1, 0);
      end
      checks++;
      if (sp_valid !== 1'b0) $display("FAIL overflow_empty: got sv=%b, want 0", sp_valid);
      else passed++;
      step(8'h00, 0, 1);
      checks++;
      if ({frame_err_cnt, csum_err_cnt, ovf_cnt} !== '0)
         $display("FAIL clr_cnt: got fe=%0d ce=%0d oc=%0d, want 0", frame_err_cnt, csum_err_cnt, ovf_cnt);
      else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(8'h80, 0, 0); step(8'h5F, 0, 0);
      rst = 1; #2; rst = 0;
      model_reset();
      step(8'h3B, 0, 0); step(8'h64, 0, 0); step(8'h00, 0, 0);
      checks++;
      if (sp_valid !== 1'b0 || busy !== 1'b0 || {frame_err_cnt, csum_err_cnt, ovf_cnt} !== '0)
         $display("FAIL reset_mid_frame: got sv=%b busy=%b fe=%0d ce=%0d oc=%0d, want all 0",
                  sp_valid, busy, frame_err_cnt, csum_err_cnt, ovf_cnt);
      else passed++;
   endtask

   // Back-to-back mixed frames, corrupted checksums, truncations, reserved headers and stalls
   task automatic test_back_to_back();
      logic [7:0] fr[$];
      logic [15:0] w;
      logic [3:0] cs;
      int kind, hold = 0;
      logic r;
      do_reset();
      for (int f = 0; f < 600; f++) begin
         fr.delete();
         kind = $urandom_range(0, 9);
         w  = 16'($urandom);
         cs = w[15:12] ^ w[11:8] ^ w[7:4] ^ w[3:0];
         if (kind < 5) begin
            if ($urandom_range(0, 6) == 0) cs = cs ^ 4'(1 << $urandom_range(0, 3));
            fr = '{8'h80 | 8'($urandom_range(0, 31)), {1'b0, w[15:9]}, {1'b0, w[8:2]},
                   {1'b0, w[1:0], 1'($urandom), cs}};
         end else if (kind < 7) begin
            fr.push_back(8'hA0 | 8'($urandom_range(0, 31)));
            for (int i = 0; i < 7; i++) fr.push_back(8'($urandom_range(0, 127)));
         end else if (kind == 7) fr.push_back(8'hC0 | 8'($urandom_range(0, 63)));
         else if (kind == 8) fr.push_back(8'($urandom_range(0, 127)));
         else fr = '{8'h80 | 8'($urandom_range(0, 31)), 8'($urandom_range(0, 127))};
         foreach (fr[i]) begin
            if (hold > 0) hold--;
            else if ($urandom_range(0, 40) == 0) hold = $urandom_range(4, 12);
            r = (hold == 0) && ($urandom_range(0, 3) != 0);
            step(fr[i], r, $urandom_range(0, 200) == 0);
            checks++;
            if (sp_valid !== (q.size() > 0) || (q.size() > 0 && sp_word !== 16'(q[0])))
               $display("FAIL rnd_sp: got v=%b w=%h, want v=%b w=%h", sp_valid, sp_word, q.size() > 0,
                        q.size() > 0 ? 16'(q[0]) : 16'h0);
            else passed++;
            checks++;
            if (clk_valid !== e_cv || clk_word !== e_cw)
               $display("FAIL rnd_clk: got cv=%b cw=%h, want cv=%b cw=%h", clk_valid, clk_word, e_cv, e_cw);
            else passed++;
            checks++;
            if (frame_err_cnt !== 16'(e_fe) || csum_err_cnt !== 16'(e_ce) || ovf_cnt !== 16'(e_oc))
               $display("FAIL rnd_cnt: got fe=%0d ce=%0d oc=%0d, want fe=%0d ce=%0d oc=%0d",
                        frame_err_cnt, csum_err_cnt, ovf_cnt, e_fe, e_ce, e_oc);
            else passed++;
            checks++;
            if (busy !== in_frame) $display("FAIL rnd_busy: got %b, want %b", busy, in_frame);
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_clock();
      test_csum();
      test_abort();
      test_overflow();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
